// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB (plus MD_WAIT for mul/div) and drives the datapath enables and one-hot selects.
module mc_ctrl_fsm #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 7
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] instr_class_i,
    input  logic       branch_taken_i,
    input  logic       mem_ready_i,
    input  logic       md_done_i,
    output logic       pc_we_o,
    output logic       ir_we_o,
    output logic       reg_we_o,
    output logic       mem_we_o,
    output logic       md_start_o,
    output logic [3:0] pc_src_sel_o,
    output logic [3:0] alu_a_sel_o,
    output logic [3:0] alu_b_sel_o,
    output logic [3:0] wb_sel_o,
    output logic       illegal_op_o,
    output logic       bus_err_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MD_WAIT = 3'd5
    } state_t;

    localparam logic [2:0] CLS_R_ALU   = 3'd0;
    localparam logic [2:0] CLS_I_ALU   = 3'd1;
    localparam logic [2:0] CLS_LOAD    = 3'd2;
    localparam logic [2:0] CLS_STORE   = 3'd3;
    localparam logic [2:0] CLS_BRANCH  = 3'd4;
    localparam logic [2:0] CLS_JUMP    = 3'd5;
    localparam logic [2:0] CLS_MULDIV  = 3'd6;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    localparam logic [3:0] OH0 = 4'b0001;
    localparam logic [3:0] OH1 = 4'b0010;
    localparam logic [3:0] OH2 = 4'b0100;

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(WAIT_LIMIT);

    state_t           state_q, state_d;
    logic [2:0]       class_q, class_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic waiting;
    logic handshake;
    logic timeout;

    // The counter holds the number of cycles already spent waiting, so the abort
    // fires on the cycle after WAIT_LIMIT unanswered cycles unless the handshake arrives.
    always_comb begin
        waiting   = (state_q == S_FETCH) || (state_q == S_MEM) || (state_q == S_MD_WAIT);
        handshake = (state_q == S_MD_WAIT) ? md_done_i : mem_ready_i;
        timeout   = waiting && !handshake && (wait_cnt_q == LIMIT_CNT);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_FETCH;
            class_q    <= 3'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                class_d = instr_class_i;
                case (instr_class_i)
                    CLS_JUMP:    state_d = S_FETCH;
                    CLS_MULDIV:  state_d = S_MD_WAIT;
                    CLS_ILLEGAL: state_d = S_FETCH;
                    default:     state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (class_q)
                    CLS_R_ALU, CLS_I_ALU: state_d = S_WB;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = (class_q == CLS_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MD_WAIT: begin
                if (md_done_i) begin
                    state_d = S_WB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        // An abort in FETCH stays in FETCH, so it must restart the count explicitly.
        if ((state_d != state_q) || timeout) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
    end

    always_comb begin
        pc_we_o      = 1'b0;
        ir_we_o      = 1'b0;
        reg_we_o     = 1'b0;
        mem_we_o     = 1'b0;
        md_start_o   = 1'b0;
        illegal_op_o = 1'b0;
        bus_err_o    = 1'b0;
        pc_src_sel_o = OH0;
        alu_a_sel_o  = OH0;
        alu_b_sel_o  = OH0;
        wb_sel_o     = OH0;
        if (rst_n_i) begin
            bus_err_o = timeout;
            case (state_q)
                S_FETCH: begin
                    alu_b_sel_o = OH1;
                    pc_we_o     = mem_ready_i;
                    ir_we_o     = mem_ready_i;
                end
                S_DECODE: begin
                    case (instr_class_i)
                        CLS_JUMP: begin
                            pc_we_o      = 1'b1;
                            pc_src_sel_o = OH2;
                        end
                        CLS_MULDIV:  md_start_o   = 1'b1;
                        CLS_ILLEGAL: illegal_op_o = 1'b1;
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    alu_a_sel_o = OH1;
                    case (class_q)
                        CLS_I_ALU, CLS_LOAD, CLS_STORE: alu_b_sel_o = OH2;
                        CLS_BRANCH: begin
                            if (branch_taken_i) begin
                                pc_we_o      = 1'b1;
                                pc_src_sel_o = OH1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_we_o = (class_q == CLS_STORE) && !timeout;
                end
                S_WB: begin
                    reg_we_o = 1'b1;
                    if (class_q == CLS_LOAD) begin
                        wb_sel_o = OH1;
                    end else if (class_q == CLS_MULDIV) begin
                        wb_sel_o = OH2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
